// File: rtl/redraw_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | redraw_pkg                                                           |
// | Shared state encoding, coordinate width and scan-end helper.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package redraw_pkg;

    localparam int XY_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FRAME = 3'd1,
        ST_FULL_SCAN  = 3'd2,
        ST_CELL_DRAW  = 3'd3,
        ST_FINISH     = 3'd4
    } redraw_state_t;

    // True on the bottom-right cell of an n x n board.
    function automatic logic last_cell(
        input logic [XY_W-1:0] x,
        input logic [XY_W-1:0] y,
        input logic [XY_W-1:0] n
    );
        return (x == n - XY_W'(1)) && (y == n - XY_W'(1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/redraw_scheduler_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | redraw_scheduler_cnt                                                 |
// | Row-major array-timing counter stepping one cell per handshake.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module redraw_scheduler_cnt
    import redraw_pkg::*;
#(
    parameter int LVL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             counting,
    input  logic [LVL_W-1:0] level,
    input  logic [XY_W-1:0]  n,
    output logic [XY_W-1:0]  x,
    output logic [XY_W-1:0]  y,
    output logic             wrap
);

    logic [XY_W-1:0] r_x;
    logic [XY_W-1:0] r_y;
    logic            w_row_end;
    logic            w_step;

    assign w_row_end = (r_x == n - XY_W'(1));
    assign wrap      = last_cell(r_x, r_y, n);
    assign w_step    = counting && (level != '0);

    // On the final cell x returns to 0 while y stays on the last row.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_step) begin
            if (w_row_end) begin
                r_x <= '0;
                if (!wrap) begin
                    r_y <= r_y + XY_W'(1);
                end
            end else begin
                r_x <= r_x + XY_W'(1);
            end
        end
    end

    assign x = r_x;
    assign y = r_y;

endmodule
`default_nettype wire

// File: rtl/redraw_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | redraw_scheduler                                                     |
// | Frame-aligned arbiter feeding full-board and single-cell redraws.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module redraw_scheduler #(
    parameter int XY_W  = 5,
    parameter int LVL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LVL_W-1:0] level,
    input  logic [XY_W-1:0]  button_num,
    input  logic             frame_start,
    input  logic             full_req,
    input  logic             cell_req,
    input  logic [XY_W-1:0]  cell_x,
    input  logic [XY_W-1:0]  cell_y,
    input  logic             draw_ack,
    output logic             draw_valid,
    output logic [XY_W-1:0]  draw_x,
    output logic [XY_W-1:0]  draw_y,
    output logic             busy,
    output logic             done
);

    import redraw_pkg::*;

    redraw_state_t    r_state;
    redraw_state_t    w_state_next;

    logic             r_pend_full;
    logic             r_pend_cell;
    logic [XY_W-1:0]  r_lat_x;
    logic [XY_W-1:0]  r_lat_y;
    logic [XY_W-1:0]  r_cell_x;
    logic [XY_W-1:0]  r_cell_y;
    logic [XY_W-1:0]  r_n;
    logic [LVL_W-1:0] r_level;
    logic             r_show_cnt;

    logic [XY_W-1:0]  w_cnt_x;
    logic [XY_W-1:0]  w_cnt_y;
    logic             w_wrap;
    logic             w_counting;
    logic             w_frame_go;
    logic             w_no_board;
    logic             w_cell_ok;
    logic             w_scan_start;
    logic             w_cell_start;

    assign w_frame_go   = (r_state == ST_WAIT_FRAME) && frame_start;
    assign w_no_board   = (level == '0);
    assign w_cell_ok    = (r_lat_x < button_num) && (r_lat_y < button_num);
    assign w_scan_start = w_frame_go && !w_no_board && r_pend_full;
    assign w_cell_start = w_frame_go && !w_no_board && !r_pend_full && w_cell_ok;
    assign w_counting   = (r_state == ST_FULL_SCAN) && draw_valid && draw_ack;

    // Board size and level are frozen at scan start so live changes cannot disturb the sweep.
    redraw_scheduler_cnt #(
        .LVL_W    (LVL_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_scan_start),
        .counting (w_counting),
        .level    (r_level),
        .n        (r_n),
        .x        (w_cnt_x),
        .y        (w_cnt_y),
        .wrap     (w_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_pend_full || r_pend_cell) begin
                    w_state_next = ST_WAIT_FRAME;
                end
            end
            ST_WAIT_FRAME: begin
                if (frame_start) begin
                    if (w_no_board) begin
                        w_state_next = ST_FINISH;
                    end else if (r_pend_full) begin
                        w_state_next = ST_FULL_SCAN;
                    end else if (w_cell_ok) begin
                        w_state_next = ST_CELL_DRAW;
                    end else begin
                        w_state_next = ST_FINISH;
                    end
                end
            end
            ST_FULL_SCAN: begin
                if (draw_ack && w_wrap) begin
                    w_state_next = ST_FINISH;
                end
            end
            ST_CELL_DRAW: begin
                if (draw_ack) begin
                    w_state_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        draw_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            ST_IDLE:       busy = 1'b0;
            ST_WAIT_FRAME: busy = 1'b1;
            ST_FULL_SCAN: begin
                busy       = 1'b1;
                draw_valid = 1'b1;
            end
            ST_CELL_DRAW: begin
                busy       = 1'b1;
                draw_valid = 1'b1;
            end
            ST_FINISH: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: busy = 1'b1;
        endcase
    end

    // New requests are applied after the frame-time clear so that a request
    // landing on the frame_start cycle is kept for the following frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_full <= 1'b0;
            r_pend_cell <= 1'b0;
            r_lat_x     <= '0;
            r_lat_y     <= '0;
        end else begin
            if (w_frame_go) begin
                r_pend_full <= 1'b0;
                r_pend_cell <= 1'b0;
            end
            if (full_req) begin
                r_pend_full <= 1'b1;
            end
            if (cell_req && !r_pend_full) begin
                r_pend_cell <= 1'b1;
                r_lat_x     <= cell_x;
                r_lat_y     <= cell_y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cell_x   <= '0;
            r_cell_y   <= '0;
            r_n        <= '0;
            r_level    <= '0;
            r_show_cnt <= 1'b0;
        end else if (w_scan_start) begin
            r_n        <= button_num;
            r_level    <= level;
            r_show_cnt <= 1'b1;
        end else if (w_cell_start) begin
            r_cell_x   <= r_lat_x;
            r_cell_y   <= r_lat_y;
            r_show_cnt <= 1'b0;
        end
    end

    assign draw_x = r_show_cnt ? w_cnt_x : r_cell_x;
    assign draw_y = r_show_cnt ? w_cnt_y : r_cell_y;

endmodule
`default_nettype wire

// File: tb/tb_redraw_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_redraw_scheduler                                                  |
// | Scoreboard bench for the redraw scheduler handshake and arbitration. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_redraw_scheduler;

    localparam int XY_W  = 5;
    localparam int LVL_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [LVL_W-1:0] level = '0;
    logic [XY_W-1:0]  button_num = '0;
    logic             frame_start = 1'b0;
    logic             full_req = 1'b0;
    logic             cell_req = 1'b0;
    logic [XY_W-1:0]  cell_x = '0;
    logic [XY_W-1:0]  cell_y = '0;
    logic             draw_ack = 1'b0;
    logic             draw_valid;
    logic [XY_W-1:0]  draw_x;
    logic [XY_W-1:0]  draw_y;
    logic             busy;
    logic             done;

    typedef struct packed {
        logic [XY_W-1:0] x;
        logic [XY_W-1:0] y;
    } cell_t;

    cell_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    redraw_scheduler #(
        .XY_W        (XY_W),
        .LVL_W       (LVL_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .level       (level),
        .button_num  (button_num),
        .frame_start (frame_start),
        .full_req    (full_req),
        .cell_req    (cell_req),
        .cell_x      (cell_x),
        .cell_y      (cell_y),
        .draw_ack    (draw_ack),
        .draw_valid  (draw_valid),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .busy        (busy),
        .done        (done)
    );

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic pulse_full();
        full_req = 1'b1;
        @(negedge clk);
        full_req = 1'b0;
    endtask

    task automatic pulse_cell(input int x, input int y);
        cell_req = 1'b1;
        cell_x   = XY_W'(x);
        cell_y   = XY_W'(y);
        @(negedge clk);
        cell_req = 1'b0;
    endtask

    task automatic push_scan(input int n);
        cell_t c;
        for (int yy = 0; yy < n; yy++) begin
            for (int xx = 0; xx < n; xx++) begin
                c.x = XY_W'(xx);
                c.y = XY_W'(yy);
                exp_q.push_back(c);
            end
        end
    endtask

    // Acts as the draw datapath: checks each presented cell against the queue,
    // acks after ack_delay held cycles and optionally fires full_req at one handshake index.
    task automatic consume(input int ack_delay, input int inject_at, input int budget,
                           output int dones, output int valids);
        int hs       = 0;
        int wait_c   = 0;
        int cyc      = 0;
        int last_ack = -10;
        int post     = -1;
        dones  = 0;
        valids = 0;
        while (cyc < budget && post != 0) begin
            full_req = 1'b0;
            if (done) begin
                dones++;
                if (hs > 0) begin
                    checks++;
                    if ((cyc - last_ack) !== 1) begin
                        errors++;
                        $display("FAIL done_latency got %0d cycles after last ack, required 1", cyc - last_ack);
                    end
                end
            end
            if (draw_valid) begin
                valids++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid got (%0d,%0d) required no draw_valid", draw_x, draw_y);
                end else if (draw_x !== exp_q[0].x || draw_y !== exp_q[0].y) begin
                    errors++;
                    $display("FAIL cell_order got (%0d,%0d) required (%0d,%0d)",
                             draw_x, draw_y, exp_q[0].x, exp_q[0].y);
                end
                if (hs == inject_at && wait_c == 0) full_req = 1'b1;
                if (wait_c >= ack_delay) begin
                    draw_ack = 1'b1;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    hs++;
                    wait_c   = 0;
                    last_ack = cyc;
                end else begin
                    draw_ack = 1'b0;
                    wait_c++;
                end
            end else begin
                draw_ack = 1'b0;
            end
            if (done && post < 0) post = 2;
            else if (post > 0) post--;
            @(negedge clk);
            cyc++;
        end
        full_req = 1'b0;
        draw_ack = 1'b0;
        if (post != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout got no done within %0d cycles, required done", budget);
        end
    endtask

    task automatic check_run(input string name, input int dones, input int valids, input int exp_valids);
        checks++;
        if (dones !== 1 || valids !== exp_valids || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL %s got done=%0d valid_cycles=%0d left=%0d required done=1 valid_cycles=%0d left=0",
                     name, dones, valids, exp_q.size(), exp_valids);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        checks++;
        if (draw_valid !== 1'b0 || draw_x !== '0 || draw_y !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got v=%b x=%0d y=%0d busy=%b done=%b required all 0",
                     draw_valid, draw_x, draw_y, busy, done);
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_full_scan();
        int d, v;
        level      = 2'd1;
        button_num = 5'd8;
        pulse_full();
        idle(1);
        checks++;
        if (busy !== 1'b1 || draw_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_frame got busy=%b valid=%b required busy=1 valid=0", busy, draw_valid);
        end
        push_scan(8);
        start_frame();
        checks++;
        if (draw_valid !== 1'b1) begin
            errors++;
            $display("FAIL valid_latency got %b required 1", draw_valid);
        end
        consume(0, -1, 400, d, v);
        check_run("full_scan", d, v, 64);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_scan got %b required 0", busy);
        end
    endtask

    task automatic test_cell_delay();
        int d, v;
        cell_t c;
        c.x = 5'd3;
        c.y = 5'd5;
        pulse_cell(3, 5);
        exp_q.push_back(c);
        idle(1);
        start_frame();
        consume(4, -1, 100, d, v);
        check_run("cell_delayed_ack", d, v, 5);
    endtask

    task automatic test_full_and_cell();
        int d, v;
        full_req = 1'b1;
        pulse_cell(2, 2);
        full_req = 1'b0;
        push_scan(8);
        idle(1);
        start_frame();
        consume(0, -1, 400, d, v);
        check_run("full_plus_cell", d, v, 64);
        start_frame();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (draw_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL dropped_cell got valid=%b busy=%b required 0 0", draw_valid, busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mid_scan_req();
        int d, v;
        pulse_full();
        push_scan(8);
        idle(1);
        start_frame();
        consume(0, 20, 400, d, v);
        check_run("mid_scan_first", d, v, 64);
        checks++;
        if (busy !== 1'b1 || draw_valid !== 1'b0) begin
            errors++;
            $display("FAIL rescan_pending got busy=%b valid=%b required busy=1 valid=0", busy, draw_valid);
        end
        push_scan(8);
        start_frame();
        consume(0, -1, 400, d, v);
        check_run("mid_scan_second", d, v, 64);
    endtask

    task automatic test_level0();
        level = 2'd0;
        pulse_full();
        idle(1);
        start_frame();
        checks++;
        if (done !== 1'b1 || draw_valid !== 1'b0) begin
            errors++;
            $display("FAIL level0_done got done=%b valid=%b required done=1 valid=0", done, draw_valid);
        end
        idle(1);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL level0_after got done=%b busy=%b required 0 0", done, busy);
        end
        level = 2'd1;
    endtask

    task automatic test_out_of_range();
        int d, v;
        pulse_cell(9, 1);
        idle(1);
        start_frame();
        consume(0, -1, 20, d, v);
        check_run("cell_out_of_range", d, v, 0);
    endtask

    task automatic test_rst_mid();
        bit found = 1'b0;
        pulse_full();
        idle(1);
        start_frame();
        for (int i = 0; i < 100 && !found; i++) begin
            if (draw_valid && draw_x == 5'd4 && draw_y == 5'd2) begin
                found    = 1'b1;
                draw_ack = 1'b0;
            end else begin
                draw_ack = draw_valid;
                @(negedge clk);
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reach_4_2 got not reached required cell (4,2)");
        end
        pulse_cell(1, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (draw_valid !== 1'b0 || draw_x !== '0 || draw_y !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_scan got v=%b x=%0d y=%0d busy=%b done=%b required all 0",
                     draw_valid, draw_x, draw_y, busy, done);
        end
        idle(2);
        start_frame();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy !== 1'b0 || draw_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_pending_lost got busy=%b valid=%b required 0 0", busy, draw_valid);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_full_scan();
        test_cell_delay();
        test_full_and_cell();
        test_mid_scan_req();
        test_level0();
        test_out_of_range();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
